// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR PRBS checker.
// Also provides the counter-width helper used by the checker.
package lfsr_pkg;

  typedef enum logic {
    StHunt = 1'b0,
    StLock = 1'b1
  } state_e;

  localparam logic [7:0] DefaultTaps = 8'hB8;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lfsr_pred_reg.sv
// Reference shift register for the PRBS checker.
// Shifts in either the received bit or its own prediction, and exposes the prediction.
module lfsr_pred_reg #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_pkg::DefaultTaps)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             sel_pred_i,
  input  logic             bit_i,
  output logic             pred_o,
  output logic [WIDTH-1:0] sr_o
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic             shift_in;

  assign pred_o   = ^(sr_q & TAPS);
  assign shift_in = sel_pred_i ? pred_o : bit_i;
  assign sr_o     = sr_q;

  always_comb begin
    sr_d = sr_q;
    if (clr_i) begin
      sr_d = '0;
    end else if (en_i) begin
      sr_d = {sr_q[WIDTH-2:0], shift_in};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS checker: hunts for lock, then flywheels and counts bit errors.
// Define LFSR_BITCNT_EN to add the bit_cnt output (valid bits seen while locked).
module lfsr_prbs_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(DefaultTaps),
  parameter int unsigned      LOCK_CNT    = 16,
  parameter int unsigned      WIN         = 64,
  parameter int unsigned      LOSS_THRESH = 4,
  parameter int unsigned      ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
`ifdef LFSR_BITCNT_EN
  ,
  output logic [31:0]      bit_cnt
`endif
);

  localparam int unsigned MatchW = cnt_w(LOCK_CNT + 1);
  localparam int unsigned WinW   = cnt_w(WIN);
  localparam int unsigned WerrW  = cnt_w(LOSS_THRESH + 1);
  localparam int unsigned FillW  = cnt_w(WIDTH + 1);

  localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_CNT - 1);
  localparam logic [WinW-1:0]   WinLast   = WinW'(WIN - 1);
  localparam logic [WerrW-1:0]  WerrLast  = WerrW'(LOSS_THRESH - 1);
  localparam logic [FillW-1:0]  FillFull  = FillW'(WIDTH);

  state_e             state_q, state_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [MatchW-1:0]  match_q, match_d;
  logic [WinW-1:0]    win_q, win_d;
  logic [WerrW-1:0]   werr_q, werr_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic               err_pulse_q, err_pulse_d;
  logic               go_hunt;
  logic               mismatch;
  logic               pred;
  logic [WIDTH-1:0]   sr;

  lfsr_pred_reg #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_pred_reg (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (bit_vld),
    .clr_i      (go_hunt),
    .sel_pred_i (state_q == StLock),
    .bit_i      (bit_in),
    .pred_o     (pred),
    .sr_o       (sr)
  );

  assign mismatch = bit_in != pred;

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_d       = win_q;
    werr_d      = werr_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    go_hunt     = 1'b0;
    if (bit_vld) begin
      unique case (state_q)
        StHunt: begin
          if (fill_q != FillFull) begin
            fill_d = fill_q + 1'b1;
          end
          // An all-zero register predicts nothing useful, so it never earns a match.
          if (fill_q == FillFull && sr != '0 && !mismatch) begin
            if (match_q == MatchLast) begin
              state_d = StLock;
              match_d = '0;
              win_d   = '0;
              werr_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            match_d = '0;
          end
        end
        StLock: begin
          err_pulse_d = mismatch;
          if (mismatch && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
          // Loss of lock wins over a window close on the same bit.
          if (mismatch && werr_q == WerrLast) begin
            go_hunt = 1'b1;
            state_d = StHunt;
            fill_d  = '0;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_q == WinLast) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + 1'b1;
            werr_d = werr_q + WerrW'(mismatch);
          end
        end
        default: ;
      endcase
    end
    if (clr_cnt) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StHunt;
      fill_q      <= '0;
      match_q     <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

`ifdef LFSR_BITCNT_EN
  logic [31:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (bit_vld && state_q == StLock && !(&bit_cnt_q)) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
    if (clr_cnt) begin
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bit_cnt = bit_cnt_q;
`endif

  assign locked    = (state_q == StLock);
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Bench for lfsr_prbs_checker: directed scenarios, a vector table and a randomized run,
// all checked against a queue-based behavioural model. Two DUTs differ only in ERR_W.
module tb_lfsr_prbs_checker;

  localparam int W    = 8;
  localparam int LOCK = 16;
  localparam int WIN  = 64;
  localparam int LOSS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_vld = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked, err_pulse, locked2, err_pulse2;
  logic [15:0] err_cnt;
  logic [1:0]  err_cnt2;
`ifdef LFSR_BITCNT_EN
  logic [31:0] bit_cnt, bit_cnt2;
`endif

  always #5 clk = ~clk;

  lfsr_prbs_checker #(
    .WIDTH(8), .TAPS(8'hB8), .LOCK_CNT(16), .WIN(64), .LOSS_THRESH(4), .ERR_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
`ifdef LFSR_BITCNT_EN
    , .bit_cnt(bit_cnt)
`endif
  );

  lfsr_prbs_checker #(
    .WIDTH(8), .TAPS(8'hB8), .LOCK_CNT(16), .WIN(64), .LOSS_THRESH(4), .ERR_W(2)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_vld(bit_vld), .clr_cnt(clr_cnt),
    .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2)
`ifdef LFSR_BITCNT_EN
    , .bit_cnt(bit_cnt2)
`endif
  );

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // Stimulus generator: the same recurrence the checker is built to track.
  logic [7:0] g = 8'h01;
  logic [7:0] taps_v = 8'hB8;

  function automatic bit gen_next();
    bit nb;
    nb = ^(g & taps_v);
    g  = {g[6:0], nb};
    return nb;
  endfunction

  // Behavioural model: m_hist[i] is the bit seen i valid cycles ago.
  bit          m_hist[$];
  bit          m_lock, m_pulse;
  int          m_match, m_pos, m_werr;
  int unsigned m_cnt;
  longint      m_bc;

  function automatic bit m_pred();
    bit p = 1'b0;
    for (int i = 0; i < m_hist.size(); i++) if (taps_v[i]) p ^= m_hist[i];
    return p;
  endfunction

  function automatic bit m_any_one();
    foreach (m_hist[i]) if (m_hist[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_push(input bit b);
    m_hist.push_front(b);
    if (m_hist.size() > W) void'(m_hist.pop_back());
  endfunction

  function automatic void model_step(input bit b, input bit v, input bit c, input bit r);
    bit p;
    if (r) begin
      m_hist.delete();
      m_lock = 0; m_pulse = 0; m_match = 0; m_pos = 0; m_werr = 0; m_cnt = 0; m_bc = 0;
      return;
    end
    m_pulse = 0;
    if (v) begin
      p = m_pred();
      if (!m_lock) begin
        if (m_hist.size() == W && m_any_one() && p == b) m_match++;
        else m_match = 0;
        m_push(b);
        if (m_match == LOCK) begin
          m_lock = 1; m_match = 0; m_pos = 0; m_werr = 0;
        end
      end else begin
        m_push(p);
        m_bc++;
        if (b != p) begin
          m_pulse = 1; m_cnt++; m_werr++;
        end
        if (m_werr == LOSS) begin
          m_lock = 0; m_hist.delete(); m_match = 0; m_pos = 0; m_werr = 0;
        end else if (m_pos == WIN - 1) begin
          m_pos = 0; m_werr = 0;
        end else begin
          m_pos++;
        end
      end
    end
    if (c) begin
      m_cnt = 0; m_bc = 0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit b, input bit v, input bit c, input bit r);
    bit_in = b; bit_vld = v; clr_cnt = c; rst = r;
    @(posedge clk);
    model_step(b, v, c, r);
    #1;
    check("locked", 32'(locked), 32'(m_lock));
    check("err_pulse", 32'(err_pulse), 32'(m_pulse));
    check("err_cnt", 32'(err_cnt), (m_cnt > 65535) ? 32'd65535 : m_cnt);
    check("err_cnt_sat", 32'(err_cnt2), (m_cnt > 3) ? 32'd3 : m_cnt);
`ifdef LFSR_BITCNT_EN
    check("bit_cnt", bit_cnt, 32'(m_bc));
`endif
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) cyc(gen_next(), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic flip();
    cyc(~gen_next(), 1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit          flip;
    bit          vld;
    bit          clr;
    bit          e_lock;
    bit          e_pulse;
    int unsigned e_cnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{0, 1, 0, 1, 0, 0};
    tbl[1] = '{1, 1, 0, 1, 1, 1};  // single error while locked
    tbl[2] = '{0, 1, 0, 1, 0, 1};
    tbl[3] = '{0, 0, 0, 1, 0, 1};  // idle cycle
    tbl[4] = '{0, 0, 0, 1, 0, 1};
    tbl[5] = '{0, 1, 1, 1, 0, 0};  // clear
    tbl[6] = '{1, 1, 1, 1, 1, 0};  // clear beats a same-cycle error
    tbl[7] = '{0, 1, 0, 1, 0, 0};

    // Reset state and clean lock after exactly 8 + 16 valid bits.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_locked", 32'(locked), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_err_pulse", 32'(err_pulse), 0);
    clean(23);
    check("t1_prelock", 32'(locked), 0);
    clean(1);
    check("t1_lock24", 32'(locked), 1);
    clean(1000);
    check("t1_clean_errs", 32'(err_cnt), 0);
    check("t1_still_locked", 32'(locked), 1);

    // Table-driven single error, idle cycles and clear priority.
    foreach (tbl[i]) begin
      bit b;
      b = tbl[i].vld ? (gen_next() ^ tbl[i].flip) : 1'($urandom);
      cyc(b, tbl[i].vld, tbl[i].clr, 1'b0);
      check($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].e_lock));
      check($sformatf("tbl%0d_pulse", i), 32'(err_pulse), 32'(tbl[i].e_pulse));
      check($sformatf("tbl%0d_cnt", i), 32'(err_cnt), tbl[i].e_cnt);
    end

    // Four errors inside one fresh window drop lock; clean stream re-locks in 24 bits.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    clean(24);
    check("t3_lock", 32'(locked), 1);
    for (int k = 0; k < 4; k++) begin
      flip();
      check($sformatf("t3_err%0d_locked", k), 32'(locked), (k < 3) ? 32'd1 : 32'd0);
      check($sformatf("t3_err%0d_pulse", k), 32'(err_pulse), 1);
    end
    check("t3_err_cnt", 32'(err_cnt), 4);
    clean(23);
    check("t3_prerelock", 32'(locked), 0);
    clean(1);
    check("t3_relock", 32'(locked), 1);

    // All-zero input never locks.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 500; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      check("t4_zero_locked", 32'(locked), 0);
    end

    // Alternating bit_vld: lock time counts valid bits only, no pulse on idle cycles.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 48; i++) begin
      if (i % 2 == 0) begin
        cyc(gen_next(), 1'b1, 1'b0, 1'b0);
      end else begin
        cyc(1'($urandom), 1'b0, 1'b0, 1'b0);
        check("t5_idle_pulse", 32'(err_pulse), 0);
      end
      if (i == 45) check("t5_prelock", 32'(locked), 0);
      if (i == 46) check("t5_lock", 32'(locked), 1);
    end

    // One error per window: narrow counter saturates, clear and reset while locked.
    for (int k = 0; k < 5; k++) begin
      flip();
      clean(63);
    end
    check("t6_err_cnt", 32'(err_cnt), 5);
    check("t6_err_cnt_sat", 32'(err_cnt2), 3);
    check("t6_locked", 32'(locked), 1);
    cyc(~gen_next(), 1'b1, 1'b1, 1'b0);
    check("t6_clr_cnt", 32'(err_cnt), 0);
    check("t6_clr_cnt_sat", 32'(err_cnt2), 0);
    check("t6_clr_pulse", 32'(err_pulse), 1);
    clean(10);
    cyc(~gen_next(), 1'b1, 1'b0, 1'b1);
    check("t6_rst_locked", 32'(locked), 0);
    check("t6_rst_pulse", 32'(err_pulse), 0);
    check("t6_rst_cnt", 32'(err_cnt), 0);

    // Randomized traffic against the model.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      bit v, f, c, r;
      v = ($urandom_range(9, 0) != 0);
      f = ($urandom_range(39, 0) == 0);
      c = ($urandom_range(199, 0) == 0);
      r = ($urandom_range(1499, 0) == 0);
      cyc(v ? (gen_next() ^ f) : 1'($urandom), v, c, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
